// File: rtl/key_debouncer.sv
// key_debouncer: per-lane 2-flop synchronizer, debounce FSM, press/release pulses.
// Optional auto-repeat of key_press while a key is held: define KEY_REPEAT_EN.
module key_debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_level_n,
    output logic key_press,
    output logic key_release
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_debouncer_lane: cycle parameters must be >= 1");
    end

    // Bit 1 of the encoding is the pressed level, so key_level_n comes straight off a flop.
    typedef enum logic [1:0] {UP = 2'b00, UP_CHK = 2'b01, DOWN = 2'b10, DOWN_CHK = 2'b11} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1, sync2;
    logic          differ, accept, press_acc, rel_acc, rpt_fire;

    assign key_level_n = ~state[1];
    assign differ      = (sync2 != key_level_n);
    assign accept      = differ && (cnt == CNT_LAST);
    assign press_acc   = accept && !sync2;
    assign rel_acc     = accept && sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= UP;
            cnt         <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= press_acc || rpt_fire;
            key_release <= rel_acc;
            if (!differ) begin
                cnt   <= '0;
                state <= key_level_n ? UP : DOWN;
            end else if (accept) begin
                cnt   <= '0;
                state <= sync2 ? UP : DOWN;
            end else begin
                cnt   <= cnt + 1'b1;
                state <= key_level_n ? UP_CHK : DOWN_CHK;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    // rpt_cnt holds cycles since the last press/repeat pulse; 0 means idle.
    logic [RW-1:0] rpt_cnt;
    logic          rpt_rep;

    assign rpt_fire = state[1] && !rel_acc &&
                      (rpt_rep ? (rpt_cnt == RW'(REPEAT_PERIOD)) : (rpt_cnt == RW'(REPEAT_DELAY)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
            rpt_rep <= 1'b0;
        end else if (press_acc) begin
            rpt_cnt <= RW'(1);
            rpt_rep <= 1'b0;
        end else if (rel_acc || !state[1]) begin
            rpt_cnt <= '0;
            rpt_rep <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt <= RW'(1);
            rpt_rep <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif
endmodule

module key_debouncer #(
    parameter int NUM_KEYS        = 5,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_raw_n,
    output logic [NUM_KEYS-1:0] key_level_n,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_debouncer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw_n  (key_raw_n[i]),
            .key_level_n(key_level_n[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end
endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer: stimulus queues expected pulse events,
// a negedge monitor pops them whenever a pulse appears and checks level every cycle.
module tb_key_debouncer;
    localparam int NK  = 5;
    localparam int DC  = 4;
    localparam int LAT = DC + 2;  // drive after edge e -> accepted at edge e+LAT

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_raw_n;
    logic [NK-1:0] key_level_n, key_press, key_release;

    key_debouncer #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_raw_n(key_raw_n),
        .key_level_n(key_level_n), .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    typedef struct {
        int            cyc;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lvl;
    } exp_t;

    exp_t          q[$];
    logic [NK-1:0] exp_lvl = '1;
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic push(input int cyc, input logic [NK-1:0] p, input logic [NK-1:0] r,
                        input logic [NK-1:0] l);
        exp_t e;
        e.cyc = cyc; e.press = p; e.rel = r; e.lvl = l;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_edge(input int n);
        while (edge_no < n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b expected %b (edge %0d)", name, act, req, edge_no);
    endtask

    // Monitor: any pulse pops one scoreboard entry; quiet cycles check the held level.
    always @(negedge clk) begin
        exp_t e;
        if ((key_press | key_release) != '0) begin
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pulse: edge %0d press=%b release=%b level=%b",
                         edge_no, key_press, key_release, key_level_n);
            end else begin
                e = q.pop_front();
                if (edge_no == e.cyc && key_press === e.press && key_release === e.rel &&
                    key_level_n === e.lvl)
                    n_pass++;
                else
                    $display("FAIL pulse_event: got edge %0d press=%b release=%b level=%b, expected edge %0d press=%b release=%b level=%b",
                             edge_no, key_press, key_release, key_level_n,
                             e.cyc, e.press, e.rel, e.lvl);
                exp_lvl = e.lvl;
            end
        end else begin
            check("level_hold", key_level_n, exp_lvl);
        end
    end

    initial begin
        int e, p, r;
        rst_n     = 1'b0;
        key_raw_n = '0;

        // Reset with every pin pressed: outputs stay released, then all lanes press together.
        step(3);
        check("reset_level", key_level_n, 5'b11111);
        check("reset_press", key_press, 5'b00000);
        check("reset_release", key_release, 5'b00000);
        rst_n = 1'b1;
        p = edge_no + LAT;
        push(p, 5'b11111, 5'b00000, 5'b00000);
        wait_edge(p);
        key_raw_n = '1;
        push(p + LAT, 5'b00000, 5'b11111, 5'b11111);
        wait_edge(p + 10);

        // Clean press on lane 0, then release.
        e = edge_no; key_raw_n[0] = 1'b0; p = e + LAT;
        push(p, 5'b00001, 5'b00000, 5'b11110);
        wait_edge(p + 1);
        key_raw_n[0] = 1'b1;
        push(p + 1 + LAT, 5'b00000, 5'b00001, 5'b11111);
        wait_edge(p + 12);

        // Bounce on lane 1: runs of 3 never reach the 4-sample threshold.
        key_raw_n[1] = 1'b0; step(3);
        key_raw_n[1] = 1'b1; step(1);
        key_raw_n[1] = 1'b0; step(3);
        key_raw_n[1] = 1'b1; step(12);

        // Press then release on lane 2.
        e = edge_no; key_raw_n[2] = 1'b0; p = e + LAT;
        push(p, 5'b00100, 5'b00000, 5'b11011);
        wait_edge(p);
        key_raw_n[2] = 1'b1;
        push(p + LAT, 5'b00000, 5'b00100, 5'b11111);
        wait_edge(p + 10);

        // Reset two counts into a lane-3 press; key held through reset re-debounces.
        e = edge_no; key_raw_n[3] = 1'b0;
        wait_edge(e + 4);
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; r = edge_no; p = r + LAT;
        push(p, 5'b01000, 5'b00000, 5'b10111);
        wait_edge(p);
        key_raw_n[3] = 1'b1;
        push(p + LAT, 5'b00000, 5'b01000, 5'b11111);
        wait_edge(p + 10);

        // Long hold on lane 4: auto-repeat when enabled, single press otherwise.
        e = edge_no; key_raw_n[4] = 1'b0; p = e + LAT;
        push(p, 5'b10000, 5'b00000, 5'b01111);
`ifdef KEY_REPEAT_EN
        push(p + 10, 5'b10000, 5'b00000, 5'b01111);
        push(p + 13, 5'b10000, 5'b00000, 5'b01111);
        push(p + 16, 5'b10000, 5'b00000, 5'b01111);
`endif
        wait_edge(p + 12);
        key_raw_n[4] = 1'b1;
        push(p + 12 + LAT, 5'b00000, 5'b10000, 5'b11111);
        wait_edge(p + 40);

        step(1);
        #1;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL missing_pulses: %0d expected events never seen, next at edge %0d",
                      q.size(), q[0].cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
